// File: rtl/app_link_pkg.sv
// Shared constants and types for the pulse-position optical link application endpoints.
// Used by both the receiver and the transmitter-side peer.
package app_link_pkg;

   localparam int N_PKT = 48;

   localparam logic [N_PKT-1:0] READY_PACKET = 48'h1f_1f1f_1f1f_99;
   localparam logic [N_PKT-1:0] ACK_PACKET   = 48'h2d_2d2d_2d2d_66;
   localparam logic [N_PKT-1:0] NAK_PACKET   = 48'ha5_a5a5_a5a5_12;

   localparam logic [31:0] TIMEOUT_TICKS  = 32'hFFFF;
   localparam int          ERRORS_ALLOWED = 8;
   localparam int          ERR_CNT_W      = $clog2(ERRORS_ALLOWED + 1);

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_TIMEOUT = 2'b01,
      ERR_RETRY   = 2'b10,
      ERR_RSVD    = 2'b11
   } err_code_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_LOAD,
      ST_TX_WAIT,
      ST_RX_WAIT,
      ST_DONE
   } link_state_e;

   function automatic logic retry_exhausted(input logic [ERR_CNT_W-1:0] cnt_next);
      return cnt_next == ERR_CNT_W'(ERRORS_ALLOWED);
   endfunction

endpackage

// File: rtl/app_enc_launcher.sv
// Encoder handshake: wait for encoder idle, fire one start pulse, then wait for the
// encoder to go busy and return idle before signalling completion.
module app_enc_launcher
   import app_link_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic launch,
   input  logic avail_enc,
   output logic start_enc,
   output logic done
);

   typedef enum logic [1:0] {
      L_IDLE,
      L_LOAD,
      L_WAIT
   } launch_state_e;

   launch_state_e state;
   logic          seen_low;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= L_IDLE;
         start_enc <= 1'b0;
         done      <= 1'b0;
         seen_low  <= 1'b0;
      end else begin
         start_enc <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            L_IDLE: begin
               if (launch) state <= L_LOAD;
            end
            L_LOAD: begin
               if (avail_enc) begin
                  start_enc <= 1'b1;
                  seen_low  <= 1'b0;
                  state     <= L_WAIT;
               end
            end
            L_WAIT: begin
               // completion needs a full busy period, not just idle right after the pulse
               if (!avail_enc) begin
                  seen_low <= 1'b1;
               end else if (seen_low) begin
                  done  <= 1'b1;
                  state <= L_IDLE;
               end
            end
            default: state <= L_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/app_packet_receiver.sv
// Receive endpoint: announce READY, take one decoder packet, answer ACK/NAK,
// present the payload or report timeout / retry exhaustion.
//
// state      | meaning
// IDLE       | waiting for start
// TX_LOAD    | control word loaded, waiting for encoder launch
// TX_WAIT    | encoder transmitting the control word
// RX_WAIT    | waiting for a decoder packet, timeout running
// DONE       | ACK sent, publish payload
module app_packet_receiver
   import app_link_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [N_PKT-1:0] data_recv,
   output logic             avail,
   output logic [1:0]       err_code,
   output logic             start_ENC,
   input  logic             avail_ENC,
   output logic [N_PKT-1:0] data_ENC,
   input  logic [N_PKT-1:0] data_DEC,
   input  logic             avail_DEC,
   input  logic             error_DEC,
   output logic             read_DEC
);

   link_state_e          state;
   logic                 launch;
   logic                 tx_done;
   logic                 tx_is_ack;
   logic [31:0]          tmo_cnt;
   logic [ERR_CNT_W-1:0] err_cnt;

   app_enc_launcher u_launcher (
      .clk       (clk),
      .rst       (rst_n),
      .launch    (launch),
      .avail_enc (avail_ENC),
      .start_enc (start_ENC),
      .done      (tx_done)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state     <= ST_IDLE;
         data_recv <= '0;
         avail     <= 1'b0;
         err_code  <= ERR_OK;
         data_ENC  <= '0;
         read_DEC  <= 1'b0;
         launch    <= 1'b0;
         tx_is_ack <= 1'b0;
         tmo_cnt   <= '0;
         err_cnt   <= '0;
      end else begin
         launch   <= 1'b0;
         read_DEC <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  data_ENC  <= READY_PACKET;
                  avail     <= 1'b0;
                  err_code  <= ERR_OK;
                  err_cnt   <= '0;
                  tx_is_ack <= 1'b0;
                  launch    <= 1'b1;
                  state     <= ST_TX_LOAD;
               end
            end
            ST_TX_LOAD: begin
               if (start_ENC) state <= ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
               if (tx_done) begin
                  if (tx_is_ack) begin
                     state <= ST_DONE;
                  end else begin
                     // down-count: reaching zero means TIMEOUT_TICKS cycles spent waiting
                     tmo_cnt <= TIMEOUT_TICKS - 32'd1;
                     state   <= ST_RX_WAIT;
                  end
               end
            end
            ST_RX_WAIT: begin
               tmo_cnt <= tmo_cnt - 32'd1;
               if (avail_DEC) begin
                  read_DEC <= 1'b1;
                  if (!error_DEC) begin
                     data_recv <= data_DEC;
                     data_ENC  <= ACK_PACKET;
                     tx_is_ack <= 1'b1;
                     launch    <= 1'b1;
                     state     <= ST_TX_LOAD;
                  end else if (retry_exhausted(err_cnt + 1'b1)) begin
                     err_cnt  <= err_cnt + 1'b1;
                     err_code <= ERR_RETRY;
                     state    <= ST_IDLE;
                  end else begin
                     err_cnt  <= err_cnt + 1'b1;
                     data_ENC <= NAK_PACKET;
                     launch   <= 1'b1;
                     state    <= ST_TX_LOAD;
                  end
               end else if (tmo_cnt == '0) begin
                  err_code <= ERR_TIMEOUT;
                  state    <= ST_IDLE;
               end
            end
            ST_DONE: begin
               avail    <= 1'b1;
               err_code <= ERR_OK;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_app_packet_receiver.sv
// Scoreboard bench for app_packet_receiver with behavioural encoder/decoder models.
module tb_app_packet_receiver;
   import app_link_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [N_PKT-1:0] data_recv;
   logic             avail;
   logic [1:0]       err_code;
   logic             start_ENC;
   logic             avail_ENC;
   logic [N_PKT-1:0] data_ENC;
   logic [N_PKT-1:0] data_DEC;
   logic             avail_DEC;
   logic             error_DEC;
   logic             read_DEC;

   typedef struct {
      logic [N_PKT-1:0] data;
      bit               bad;
   } pkt_t;

   typedef struct {
      bit               avail;
      logic [1:0]       err;
      logic [N_PKT-1:0] data;
      int               reads;
      int               txs;
   } res_t;

   pkt_t             dec_q[$];
   logic [N_PKT-1:0] exp_tx[$];
   res_t             exp_res[$];

   int   checks = 0;
   int   errors = 0;
   int   n_tx;
   int   n_rd;
   bit   mon_off;
   logic prev_avail;
   logic [1:0] prev_err;

   app_packet_receiver dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .data_recv (data_recv),
      .avail     (avail),
      .err_code  (err_code),
      .start_ENC (start_ENC),
      .avail_ENC (avail_ENC),
      .data_ENC  (data_ENC),
      .data_DEC  (data_DEC),
      .avail_DEC (avail_DEC),
      .error_DEC (error_DEC),
      .read_DEC  (read_DEC)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [N_PKT-1:0] rand48();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[N_PKT-1:0];
   endfunction

   // encoder: goes busy for a random time after each start pulse
   initial begin
      avail_ENC = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (start_ENC) begin
            avail_ENC = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            avail_ENC = 1'b1;
         end
      end
   end

   // decoder: holds the head packet until read
   initial begin
      avail_DEC = 1'b0;
      error_DEC = 1'b0;
      data_DEC  = '0;
      forever begin
         @(posedge clk); #1;
         if (avail_DEC && read_DEC) begin
            if (dec_q.size() > 0) dec_q.delete(0);
            avail_DEC = 1'b0;
         end else if (!avail_DEC && dec_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            data_DEC  = dec_q[0].data;
            error_DEC = dec_q[0].bad;
            avail_DEC = 1'b1;
         end
      end
   end

   // monitor
   initial begin
      res_t r;
      prev_avail = 1'b0;
      prev_err   = 2'b00;
      n_tx = 0;
      n_rd = 0;
      forever begin
         @(negedge clk);
         if (!mon_off && !rst_n) begin
            if (start_ENC) begin
               n_tx++;
               if (exp_tx.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL tx_unexpected: got word %h, expected no transmission", data_ENC);
               end else begin
                  check("tx_word", 64'(data_ENC), 64'(exp_tx.pop_front()));
               end
            end
            if (read_DEC) n_rd++;
            if ((avail && !prev_avail) || (err_code != 2'b00 && prev_err == 2'b00)) begin
               if (exp_res.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL result_unexpected: got avail=%0d err=%0d, expected no completion", avail, err_code);
               end else begin
                  r = exp_res.pop_front();
                  check("res_avail", 64'(avail), 64'(r.avail));
                  check("res_err_code", 64'(err_code), 64'(r.err));
                  if (r.avail) check("res_data_recv", 64'(data_recv), 64'(r.data));
                  check("res_read_count", 64'(n_rd), 64'(r.reads));
                  check("res_tx_count", 64'(n_tx), 64'(r.txs));
               end
               n_tx = 0;
               n_rd = 0;
            end
         end
         prev_avail = avail;
         prev_err   = err_code;
      end
   end

   // reference: walk the packet list applying the ACK/NAK/retry rules
   task automatic do_transfer(input int n_bad, input bit with_good, input logic [N_PKT-1:0] good,
                              input int budget, output int elapsed);
      res_t r;
      pkt_t p;
      int   errs = 0;
      bit   settled = 0;
      bit   fin = 0;
      int   cyc = 0;
      int   rise_at = 0;
      logic prev_enc;
      r.avail = 1'b0;
      r.err   = ERR_TIMEOUT;
      r.data  = '0;
      r.reads = 0;
      r.txs   = 1;
      exp_tx.push_back(READY_PACKET);
      for (int i = 0; i < n_bad + (with_good ? 1 : 0) && !settled; i++) begin
         p.bad  = (i < n_bad);
         p.data = p.bad ? rand48() : good;
         dec_q.push_back(p);
         r.reads++;
         if (!p.bad) begin
            exp_tx.push_back(ACK_PACKET);
            r.txs++;
            r.avail = 1'b1;
            r.err   = ERR_OK;
            r.data  = good;
            settled = 1;
         end else begin
            errs++;
            if (errs == ERRORS_ALLOWED) begin
               r.err   = ERR_RETRY;
               settled = 1;
            end else begin
               exp_tx.push_back(NAK_PACKET);
               r.txs++;
            end
         end
      end
      exp_res.push_back(r);

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("start_clears_err", 64'(err_code), 64'(ERR_OK));
      check("start_clears_avail", 64'(avail), 64'd0);

      elapsed  = 0;
      prev_enc = avail_ENC;
      while (!fin && cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (avail_ENC && !prev_enc) rise_at = cyc;
         prev_enc = avail_ENC;
         if (avail || err_code != 2'b00) begin
            fin = 1;
            elapsed = cyc - rise_at;
         end else if (!avail_ENC && $urandom_range(0, 3) == 0) begin
            start = 1'b1;  // busy: must be ignored
         end
      end
      start = 1'b0;
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL transfer_done: no completion within %0d cycles", budget);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int el;
      int cyc;
      mon_off = 0;
      rst_n   = 1'b1;
      start   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_avail", 64'(avail), 64'd0);
      check("rst_data_recv", 64'(data_recv), 64'd0);
      check("rst_err_code", 64'(err_code), 64'd0);
      check("rst_start_enc", 64'(start_ENC), 64'd0);
      check("rst_read_dec", 64'(read_DEC), 64'd0);
      check("rst_data_enc", 64'(data_ENC), 64'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      do_transfer(0, 1, 48'h3c123feedbac, 3000, el);
      do_transfer(2, 1, 48'h0123456789ab, 3000, el);
      do_transfer(8, 1, rand48(), 3000, el);

      do_transfer(0, 0, '0, 70000, el);
      checks++;
      if (el < 65535 || el > 65545) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles, expected 65535..65545", el);
      end
      do_transfer(0, 1, rand48(), 3000, el);

      // reset while the READY word is in flight
      mon_off = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (avail_ENC && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (avail_ENC) begin
         checks++;
         errors++;
         $display("FAIL reset_setup: encoder never went busy, got avail_ENC=1 expected 0");
      end
      rst_n = 1'b1;
      #1;
      check("midrst_avail", 64'(avail), 64'd0);
      check("midrst_data_recv", 64'(data_recv), 64'd0);
      check("midrst_err_code", 64'(err_code), 64'd0);
      check("midrst_start_enc", 64'(start_ENC), 64'd0);
      check("midrst_read_dec", 64'(read_DEC), 64'd0);
      check("midrst_data_enc", 64'(data_ENC), 64'd0);
      dec_q.delete();
      avail_DEC = 1'b0;
      exp_tx.delete();
      exp_res.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      cyc = 0;
      while (!avail_ENC && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      n_tx = 0;
      n_rd = 0;
      mon_off = 0;

      do_transfer(1, 1, rand48(), 3000, el);
      for (int i = 0; i < 14; i++) begin
         do_transfer(int'($urandom_range(0, 9)), 1, rand48(), 3000, el);
      end

      repeat (5) @(negedge clk);
      check("queues_drained", 64'(exp_tx.size() + exp_res.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
